split_count_sequencer: RTL

Sequences the beam tracker for one puzzle run and turns its per-line active-splitter vectors into the final split count. Sits between the line decoder, which supplies one splitter bitmap per grid row over a valid/ready handshake, and the beam tracker. It forwards each non-empty row to the tracker and popcounts the returned activated-splitter vector in CHUNK_WIDTH slices over several cycles. After the row flagged last, it presents the accumulated total on a held result handshake.

---
 rtl/split_count_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/split_count_sequencer.sv
// Forwards non-empty splitter rows to the beam tracker, popcounts each tracker
// response CHUNK_WIDTH bits per cycle, and offers the grid total on a held result port.
module split_count_sequencer #(
  parameter int LINE_WIDTH   = 141,
  parameter int CHUNK_WIDTH  = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LINE_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic                    line_valid,
  output logic [LINE_WIDTH-1:0]   line_data,
  input  logic                    active_splitters_valid,
  input  logic [LINE_WIDTH-1:0]   active_splitters_data,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [RESULT_WIDTH-1:0] result_data,
  output logic [2:0]              dbg_state
);

  localparam int N  = (LINE_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PW = N * CHUNK_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [LINE_WIDTH-1:0]   r_line_data;
  logic                    r_line_valid;
  logic                    r_last;
  logic [PW-1:0]           r_shift;
  logic [IW-1:0]           r_idx;
  logic [RESULT_WIDTH-1:0] r_acc;
  logic                    r_result_valid;
  logic [RESULT_WIDTH-1:0] w_pop;

  // Handshakes: a row transfers on a rising edge where in_valid && in_ready; the
  // result transfers where result_valid && result_ready, and is held until then.
  assign in_ready     = (r_state == S_IDLE) && rst_n;
  assign line_valid   = r_line_valid;
  assign line_data    = r_line_data;
  assign result_valid = r_result_valid;
  assign result_data  = r_acc;
  assign dbg_state    = r_state;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_pop = w_pop + RESULT_WIDTH'(r_shift[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_line_data    <= '0;
      r_line_valid   <= 1'b0;
      r_last         <= 1'b0;
      r_shift        <= '0;
      r_idx          <= '0;
      r_acc          <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_line_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_data != '0) begin
              r_line_data  <= in_data;
              r_last       <= in_last;
              r_line_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end else if (in_last) begin
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          // The tracker answers exactly one cycle after the pulse; stalling here is defensive.
          if (active_splitters_valid) begin
            r_shift <= PW'(active_splitters_data);
            r_idx   <= '0;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          r_acc   <= r_acc + w_pop;
          r_shift <= r_shift >> CHUNK_WIDTH;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            if (r_last) begin
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_acc          <= '0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
